// File: rtl/calc_job_sequencer.sv
// calc_job_sequencer
//   Collects one calculator operation from keypad strobes (operand A,
//   operator, operand B), writes it to a four-word mailbox in the ARM data
//   memory, raises the start flag, polls for the done flag and reads the
//   result back for display. This block is the only calculator-side owner
//   of the memory write port.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-low reset
//   key_valid    one-cycle strobe qualifying key_code
//   key_code     0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 AND, 14 EQUALS, 15 CLEAR
//   mem_addr     data memory byte address
//   mem_wdata    data memory write data
//   mem_we       data memory write enable (one word per cycle)
//   mem_rdata    data memory read data, valid the cycle after mem_addr
//   display_num  operand being typed, or the last result
//   digit_count  digits typed into the current operand
//   busy         high while the mailbox transaction is in progress
//   error        sticky poll-timeout flag, cleared by CLEAR or reset
module calc_job_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0040,
  parameter int          MAX_DIGITS   = 8,
  parameter int          POLL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [31:0] display_num,
  output logic [3:0]  digit_count,
  output logic        busy,
  output logic        error
);

  localparam int              PW        = $clog2(POLL_TIMEOUT + 1);
  localparam logic [3:0]      MAX_CNT   = 4'(MAX_DIGITS);
  localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_TIMEOUT - 1);
  localparam logic [31:0]     FLAG_ADDR = BASE_ADDR + 32'd12;

  typedef enum logic [3:0] {
    ENTER_A, ENTER_B, WR_A, WR_B, WR_OP, WR_GO, POLL, RD_RES1, RD_RES2, SHOW
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [31:0]   display_q, display_d;
  logic          error_q, error_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;

  logic        is_digit, is_op, is_eq, is_clr;
  logic [3:0]  op_off;
  logic [31:0] acc_mac;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = key_valid && (key_code == 4'd14);
  assign is_clr   = key_valid && (key_code == 4'd15);
  assign op_off   = key_code - 4'd10;
  assign acc_mac  = acc_q * 32'd10 + {28'd0, key_code};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ENTER_A;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      count_q     <= '0;
      poll_cnt_q  <= '0;
      display_q   <= '0;
      error_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      count_q     <= count_d;
      poll_cnt_q  <= poll_cnt_d;
      display_q   <= display_d;
      error_q     <= error_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath. SHOW shares the ENTER_A key handling; acc and
  // count are already zero there, so the first digit simply starts operand A
  // and only then does display_num leave the result.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    count_d    = count_q;
    poll_cnt_d = poll_cnt_q;
    display_d  = display_q;
    error_d    = error_q;

    case (state_q)
      ENTER_A, SHOW, ENTER_B: begin
        if (is_digit) begin
          if (count_q < MAX_CNT) begin
            acc_d     = acc_mac;
            count_d   = count_q + 4'd1;
            display_d = acc_mac;
            if (state_q == SHOW) state_d = ENTER_A;
          end
        end else if (is_op) begin
          op_d = op_off[1:0];
          if (state_q != ENTER_B) begin
            // With no digits typed, A keeps the previous result for chaining.
            if (count_q != 4'd0) a_d = acc_q;
            acc_d     = '0;
            count_d   = '0;
            display_d = '0;
            state_d   = ENTER_B;
          end
        end else if (is_eq) begin
          if (state_q == ENTER_B) begin
            b_d     = acc_q;
            acc_d   = '0;
            count_d = '0;
            state_d = WR_A;
          end
        end else if (is_clr) begin
          acc_d     = '0;
          count_d   = '0;
          a_d       = '0;
          b_d       = '0;
          op_d      = '0;
          error_d   = 1'b0;
          display_d = '0;
          state_d   = ENTER_A;
        end
      end
      WR_A:  state_d = WR_B;
      WR_B:  state_d = WR_OP;
      WR_OP: state_d = WR_GO;
      WR_GO: begin
        poll_cnt_d = '0;
        state_d    = POLL;
      end
      POLL: begin
        // The first POLL cycle returns the flag as read during the WR_GO
        // write, which may still be a stale done; it is never trusted.
        if ((poll_cnt_q != '0) && (mem_rdata == 32'd2)) begin
          state_d = RD_RES1;
        end else if (poll_cnt_q == POLL_LAST) begin
          error_d   = 1'b1;
          display_d = '0;
          state_d   = SHOW;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      RD_RES1: state_d = RD_RES2;
      RD_RES2: begin
        a_d       = mem_rdata;
        display_d = mem_rdata;
        state_d   = SHOW;
      end
      default: state_d = ENTER_A;
    endcase
  end

  // Memory-side outputs are registered from the next state so they line up
  // with the state they belong to and all read zero while reset is held.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = FLAG_ADDR;
    mem_wdata_d = '0;
    busy_d      = 1'b1;
    case (state_d)
      WR_A: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_ADDR;
        mem_wdata_d = a_q;
      end
      WR_B: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_ADDR + 32'd4;
        mem_wdata_d = b_q;
      end
      WR_OP: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = BASE_ADDR + 32'd8;
        mem_wdata_d = {30'd0, op_q};
      end
      WR_GO: begin
        mem_we_d    = 1'b1;
        mem_wdata_d = 32'd1;
      end
      POLL:             mem_addr_d = FLAG_ADDR;
      RD_RES1, RD_RES2: mem_addr_d = BASE_ADDR;
      default:          busy_d     = 1'b0;
    endcase
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign display_num = display_q;
  assign digit_count = count_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule

// File: tb/tb_calc_job_sequencer.sv
// tb_calc_job_sequencer
//   Drives keypad sequences into calc_job_sequencer, models the ARM-side
//   mailbox memory and processor, and checks memory writes through a
//   scoreboard queue plus directed checks on the display/status outputs.
`timescale 1ns/1ps
module tb_calc_job_sequencer;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_MUL = 4'd12;
  localparam logic [3:0] K_AND = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, display_num;
  logic        mem_we, busy, error;
  logic [3:0]  digit_count;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  // Processor model controls.
  logic        proc_enable = 1'b1;
  int          proc_delay  = 5;
  logic [31:0] mbox [4];
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] rd_data = '0;

  assign mem_rdata = rd_data;

  calc_job_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .display_num (display_num),
    .digit_count (digit_count),
    .busy        (busy),
    .error       (error)
  );

  always #20 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) mbox[i] = '0;
  end

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return a & b;
    endcase
  endfunction

  // Mailbox memory with synchronous read (read-before-write) and a
  // processor that posts the result some cycles after the start flag.
  always @(posedge clk) begin
    logic in_rng;
    logic [1:0] idx;
    in_rng = (mem_addr >= 32'h40) && (mem_addr <= 32'h4C);
    idx    = 2'((mem_addr - 32'h40) >> 2);
    rd_data <= in_rng ? mbox[idx] : 32'd0;
    if (mem_we && in_rng) mbox[idx] <= mem_wdata;
    if (mem_we && mem_addr == 32'h4C && mem_wdata == 32'd1) begin
      pend     <= 1'b1;
      pend_cnt <= proc_delay;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        if (proc_enable) begin
          mbox[0] <= calc(mbox[0], mbox[1], mbox[2]);
          mbox[3] <= 32'd2;
        end
        pend <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  // Scoreboard monitor: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected",
                 mem_addr, mem_wdata);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (mem_addr !== w.addr || mem_wdata !== w.data) begin
          n_fail++;
          $display("[TB] FAIL mem_write: got (0x%08h,0x%08h) expected (0x%08h,0x%08h)",
                   mem_addr, mem_wdata, w.addr, w.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  task automatic expectJob(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] op);
    exp_q.push_back('{32'h40, a});
    exp_q.push_back('{32'h44, b});
    exp_q.push_back('{32'h48, op});
    exp_q.push_back('{32'h4C, 32'd1});
  endtask

  // Called at the negedge right after the EQUALS strobe: exactly four
  // consecutive write cycles, then POLL on the flag address.
  task automatic checkBurst();
    checkOutput("busy_after_eq", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("we_cycle%0d", i), {31'd0, mem_we}, 32'd1);
      @(negedge clk);
    end
    checkOutput("we_after_burst", {31'd0, mem_we}, 32'd0);
    checkOutput("poll_addr", mem_addr, 32'h4C);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge clk);
    checkOutput("idle_within_budget", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_display", display_num, 32'd0);
    checkOutput("rst_busy_err", {30'd0, busy, error}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_addr", mem_addr, 32'h4C);

    // 12 + 3 = 15
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    checkOutput("disp_12", display_num, 32'd12);
    checkOutput("count_2", {28'd0, digit_count}, 32'd2);
    applyStimulus(K_ADD);
    checkOutput("disp_after_op", display_num, 32'd0);
    applyStimulus(4'd3);
    checkOutput("disp_3", display_num, 32'd3);
    expectJob(32'd12, 32'd3, 32'd0);
    applyStimulus(K_EQ);
    checkBurst();
    waitIdle(200);
    checkOutput("result_15", display_num, 32'd15);
    checkOutput("show_err", {31'd0, error}, 32'd0);

    // Chaining: SUB 5 uses the previous result as A
    applyStimulus(K_SUB);
    applyStimulus(4'd5);
    expectJob(32'd15, 32'd5, 32'd1);
    applyStimulus(K_EQ);
    checkBurst();
    waitIdle(200);
    checkOutput("result_10", display_num, 32'd10);

    // Digit limit
    applyStimulus(K_CLR);
    for (int d = 1; d <= 9; d++) applyStimulus(4'(d));
    checkOutput("count_max", {28'd0, digit_count}, 32'd8);
    checkOutput("disp_max", display_num, 32'd12345678);
    applyStimulus(K_CLR);
    checkOutput("clr_disp", display_num, 32'd0);
    checkOutput("clr_count", {28'd0, digit_count}, 32'd0);

    // Poll timeout: processor never answers
    proc_enable = 1'b0;
    applyStimulus(4'd7);
    applyStimulus(K_MUL);
    applyStimulus(4'd6);
    expectJob(32'd7, 32'd6, 32'd2);
    applyStimulus(K_EQ);
    checkBurst();
    repeat (1023) @(negedge clk);
    checkOutput("no_err_before_timeout", {30'd0, busy, error}, 32'd2);
    @(negedge clk);
    checkOutput("err_at_timeout", {30'd0, busy, error}, 32'd1);
    checkOutput("timeout_disp", display_num, 32'd0);
    applyStimulus(K_CLR);
    checkOutput("clr_err", {31'd0, error}, 32'd0);

    // Keys during POLL are dropped: 14 AND 7 = 6
    proc_enable = 1'b1;
    proc_delay  = 20;
    applyStimulus(4'd1);
    applyStimulus(4'd4);
    applyStimulus(K_AND);
    applyStimulus(4'd7);
    expectJob(32'd14, 32'd7, 32'd3);
    applyStimulus(K_EQ);
    checkBurst();
    applyStimulus(4'd5);
    applyStimulus(K_ADD);
    applyStimulus(K_CLR);
    applyStimulus(K_EQ);
    waitIdle(200);
    checkOutput("result_6", display_num, 32'd6);
    checkOutput("post_poll_count", {28'd0, digit_count}, 32'd0);
    applyStimulus(K_ADD);
    applyStimulus(4'd1);
    expectJob(32'd6, 32'd1, 32'd0);
    applyStimulus(K_EQ);
    checkBurst();
    waitIdle(200);
    checkOutput("result_7", display_num, 32'd7);

    // Reset during WR_B
    proc_delay = 3;
    applyStimulus(4'd2);
    applyStimulus(K_ADD);
    applyStimulus(4'd2);
    exp_q.push_back('{32'h40, 32'd2});
    applyStimulus(K_EQ);
    checkOutput("we_wr_a", {31'd0, mem_we}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_we", {31'd0, mem_we}, 32'd0);
    checkOutput("async_addr", mem_addr, 32'd0);
    checkOutput("async_display", display_num, 32'd0);
    checkOutput("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("after_rst_addr", mem_addr, 32'h4C);
    applyStimulus(4'd4);
    checkOutput("after_rst_disp", display_num, 32'd4);
    checkOutput("after_rst_count", {28'd0, digit_count}, 32'd1);
    applyStimulus(K_ADD);
    applyStimulus(4'd5);
    expectJob(32'd4, 32'd5, 32'd0);
    applyStimulus(K_EQ);
    checkBurst();
    waitIdle(200);
    checkOutput("result_9", display_num, 32'd9);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_job_sequencer.md
Name: calc_job_sequencer

Overview:
- Sequences one calculator operation between the keypad decode and the ARM processor's shared data memory.
- Accumulates decimal keystrokes into operand A, operator and operand B, then writes them to a fixed mailbox in data memory and raises a start flag.
- Polls the mailbox until the processor posts done, then reads the result back for display.
- Replaces ad-hoc WE/address generation with a single owner of the memory write port on the calculator side.

Parameters:
- BASE_ADDR, 32'h0000_0040, byte address of mailbox word 0.
- MAX_DIGITS, 8, maximum decimal digits per operand.
- POLL_TIMEOUT, 1024, clk cycles allowed in POLL before error.

Ports:
- clk  in  1  system clock (25 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0-9 digit; 10 ADD; 11 SUB; 12 MUL; 13 AND; 14 EQUALS; 15 CLEAR.
- mem_addr  out  32  data memory byte address.
- mem_wdata  out  32  write data.
- mem_we  out  1  write enable, one word per cycle.
- mem_rdata  in  32  read data, valid one cycle after mem_addr (synchronous read).
- display_num  out  32  value to show (operand being typed or result).
- digit_count  out  4  digits typed in current operand.
- busy  out  1  high from WR_A through RD_RES.
- error  out  1  sticky timeout flag; cleared by CLEAR or reset.

Behaviour:
- Mailbox layout: BASE+0 = A, BASE+4 = B, BASE+8 = opcode (0 ADD, 1 SUB, 2 MUL, 3 AND), BASE+12 = flag (1 = start, 2 = done).
- Reset values: all outputs 0; state ENTER_A; internal acc, A, B and op all 0.
- ENTER_A, digit key:
  - If digit_count < MAX_DIGITS: acc <= acc*10 + digit (32-bit unsigned, wraps mod 2^32), digit_count++.
  - Otherwise the key is dropped.
- ENTER_A, operator key:
  - A <= acc; op latched; acc and count cleared; go to ENTER_B.
  - If count == 0, A keeps the last result (chaining).
- ENTER_A, EQUALS: ignored.
- ENTER_B, digit key: same accumulation rule as ENTER_A.
- ENTER_B, operator key: op replaced; no other change.
- ENTER_B, EQUALS: B <= acc (0 if no digits typed); go to WR_A.
- CLEAR in ENTER_A, ENTER_B or SHOW: acc, count, A, B, op and error cleared; go to ENTER_A.
- CLEAR in any busy state: ignored.
- Any key while busy is dropped; no queueing.
- Write sequence, one state per cycle with mem_we = 1 in each:
  - WR_A: addr BASE, data A.
  - WR_B: addr BASE+4, data B.
  - WR_OP: addr BASE+8, data op.
  - WR_GO: addr BASE+12, data 1.
- POLL: mem_we = 0; mem_addr = BASE+12; compare mem_rdata the cycle after entry and every cycle thereafter.
  - mem_rdata == 2: go to RD_RES.
  - Timeout counter reaches POLL_TIMEOUT: error <= 1, display_num <= 0, go to SHOW.
- RD_RES, 2 cycles:
  - Cycle 1: addr BASE+0.
  - Cycle 2: capture mem_rdata as result, A <= result, display_num <= result.
  - Go to SHOW.
- SHOW: behaves as ENTER_A with acc = 0, but display_num stays at the result until the first digit arrives.
- display_num in ENTER states = acc; updates the cycle after key_valid.
- Latency: EQUALS strobe to first mem_we = 1 cycle; mem_we high for exactly 4 consecutive cycles.
- mem_we is never asserted outside WR_* states.
- mem_addr holds BASE+12 in all idle states.
- Async reset mid-sequence aborts immediately. The memory flag is left as-is; the processor side owns cleanup.

Test Plan:
- Keys 1,2,ADD,3,EQUALS; model writes 2 to flag 5 cycles after start, result 15 -> mem writes (0x40,12), (0x44,3), (0x48,0), (0x4C,1) on consecutive cycles; display_num = 15; busy low in SHOW.
- Nine digit keys "123456789" -> digit_count = 8, display_num = 12345678; ninth key dropped.
- After result 15, press SUB,5,EQUALS -> A written as 15, op 1, B 5 (chaining).
- Model never posts done -> error = 1 exactly POLL_TIMEOUT cycles into POLL; display_num = 0; CLEAR then clears error.
- Keys and CLEAR pulsed during POLL -> ignored; post-completion state matches the run with no extra keys.
- reset low during WR_B -> all outputs 0 asynchronously; mem_we drops within the same cycle; state ENTER_A after release.
